// File: rtl/timer_pkg.sv
// Shared encodings for the timer bank.
//   mode_t  : per-channel counting mode, matches the 2-bit cfg_mode field
//   state_t : per-channel run state
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_UPCMP   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_EXPIRED = 2'b10
  } state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: mode, load, count and run state.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_we          decoded configuration write for this channel
//   cfg_mode        mode to write (timer_pkg::mode_t encoding)
//   cfg_load        reload / compare value to write
//   en              count enable
//   count           registered counter value
//   valid           count was updated on the last edge
//   done            one-cycle terminal-event pulse, aligned with valid
//
// state      | meaning
// ST_IDLE    | configured or reset, not yet counted
// ST_RUN     | has counted at least once since configuration
// ST_EXPIRED | oneshot finished; ignores en until reconfigured
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             valid,
  output logic             done
);

  mode_t            mode, mode_nxt;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] load, load_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             valid_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode  <= MODE_UP;
      state <= ST_IDLE;
      load  <= '0;
      count <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      mode  <= mode_nxt;
      state <= state_nxt;
      load  <= load_nxt;
      count <= count_nxt;
      valid <= valid_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    mode_nxt  = mode;
    state_nxt = state;
    load_nxt  = load;
    count_nxt = count;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    if (cfg_we) begin
      // Configuration overrides any same-cycle enable.
      mode_nxt  = mode_t'(cfg_mode);
      load_nxt  = cfg_load;
      state_nxt = ST_IDLE;
      if (mode_t'(cfg_mode) == MODE_UP || mode_t'(cfg_mode) == MODE_UPCMP)
        count_nxt = '0;
      else
        count_nxt = cfg_load;
    end else if (en && state != ST_EXPIRED) begin
      valid_nxt = 1'b1;
      state_nxt = ST_RUN;
      unique case (mode)
        MODE_UP: begin
          count_nxt = count + WIDTH'(1);
          done_nxt  = &count;
        end
        MODE_UPCMP: begin
          if (count == load) begin
            count_nxt = '0;
            done_nxt  = 1'b1;
          end else begin
            count_nxt = count + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (count == '0) begin
            count_nxt = load;
            done_nxt  = 1'b1;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
        MODE_ONESHOT: begin
          if (count <= WIDTH'(1)) begin
            count_nxt = '0;
            done_nxt  = 1'b1;
            state_nxt = ST_EXPIRED;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of CHANNELS independent timers sharing one configuration port.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   cfg_we     configuration write strobe
//   cfg_ch     target channel; values >= CHANNELS are ignored
//   cfg_mode   00 UP, 01 DOWN, 10 ONESHOT, 11 UP_CMP
//   cfg_load   reload value (DOWN/ONESHOT) or compare value (UP_CMP)
//   t_en       per-channel count enable
//   t_valid    per-channel update flag
//   t_out      packed counters, channel i at [i*WIDTH +: WIDTH]
//   t_done     per-channel terminal-event pulse
module timer_bank
  import timer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [1:0]                cfg_mode,
  input  logic [WIDTH-1:0]          cfg_load,
  input  logic [CHANNELS-1:0]       t_en,
  output logic [CHANNELS-1:0]       t_valid,
  output logic [CHANNELS*WIDTH-1:0] t_out,
  output logic [CHANNELS-1:0]       t_done
);

  logic [CHANNELS-1:0] cfg_sel;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Out-of-range cfg_ch matches no channel, so the write is dropped.
    assign cfg_sel[i] = cfg_we && (cfg_ch == CH_W'(i));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_sel[i]),
      .cfg_mode (cfg_mode),
      .cfg_load (cfg_load),
      .en       (t_en[i]),
      .count    (t_out[i*WIDTH +: WIDTH]),
      .valid    (t_valid[i]),
      .done     (t_done[i])
    );
  end

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int CH_W     = 3;

  logic                      clk;
  logic                      rst;
  logic                      cfg_we;
  logic [CH_W-1:0]           cfg_ch;
  logic [1:0]                cfg_mode;
  logic [WIDTH-1:0]          cfg_load;
  logic [CHANNELS-1:0]       t_en;
  logic [CHANNELS-1:0]       t_valid;
  logic [CHANNELS*WIDTH-1:0] t_out;
  logic [CHANNELS-1:0]       t_done;

  int checks   = 0;
  int failures = 0;

  timer_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_load (cfg_load),
    .t_en     (t_en),
    .t_valid  (t_valid),
    .t_out    (t_out),
    .t_done   (t_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ch(input int i);
    return t_out[i*WIDTH +: WIDTH];
  endfunction

  task automatic cfg(input int c, input logic [1:0] m, input logic [15:0] ld);
    cfg_we   = 1'b1;
    cfg_ch   = CH_W'(c);
    cfg_mode = m;
    cfg_load = ld;
  endtask

  initial begin
    int exp_dn [5];
    int exp_cmp[4];
    exp_dn  = '{2, 1, 0, 3, 2};
    exp_cmp = '{1, 2, 0, 1};

    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = 2'b00; cfg_load = '0; t_en = '0;
    step(); step();
    chk("reset_out",   t_out[31:0], 32'h0);
    chk("reset_out_h", t_out[63:32], 32'h0);
    chk("reset_valid", 32'(t_valid), 32'h0);
    chk("reset_done",  32'(t_done), 32'h0);
    rst = 1'b0;

    // UP basic count and hold
    t_en = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("up_count", 32'(ch(0)), 32'(k));
      chk("up_valid", 32'(t_valid[0]), 32'h1);
      chk("up_done",  32'(t_done[0]), 32'h0);
    end
    t_en = 4'b0000;
    step();
    chk("up_hold_valid", 32'(t_valid[0]), 32'h0);
    chk("up_hold_count", 32'(ch(0)), 32'h3);

    // UP wrap FFFF -> 0000
    cfg(0, 2'b00, 16'h0);
    step();
    cfg_we = 1'b0;
    chk("up_cfg_count", 32'(ch(0)), 32'h0);
    chk("up_cfg_valid", 32'(t_valid[0]), 32'h0);
    t_en = 4'b0001;
    repeat (65533) step();
    chk("wrap_pre",    32'(ch(0)), 32'hFFFD);
    step();
    chk("wrap_fffe",   32'(ch(0)), 32'hFFFE);
    chk("wrap_fffe_d", 32'(t_done[0]), 32'h0);
    step();
    chk("wrap_ffff",   32'(ch(0)), 32'hFFFF);
    chk("wrap_ffff_d", 32'(t_done[0]), 32'h0);
    step();
    chk("wrap_0000",   32'(ch(0)), 32'h0);
    chk("wrap_0000_d", 32'(t_done[0]), 32'h1);
    chk("wrap_0000_v", 32'(t_valid[0]), 32'h1);
    step();
    chk("wrap_0001",   32'(ch(0)), 32'h1);
    chk("wrap_0001_d", 32'(t_done[0]), 32'h0);
    t_en = 4'b0000;

    // Ch1 DOWN load 3
    cfg(1, 2'b01, 16'd3);
    step();
    cfg_we = 1'b0;
    chk("dn_preset", 32'(ch(1)), 32'd3);
    t_en = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("dn_count", 32'(ch(1)), 32'(exp_dn[k]));
      chk("dn_valid", 32'(t_valid[1]), 32'h1);
      chk("dn_done",  32'(t_done[1]), (k == 3) ? 32'h1 : 32'h0);
    end
    t_en = 4'b0000;

    // Ch2 ONESHOT load 2
    cfg(2, 2'b10, 16'd2);
    step();
    cfg_we = 1'b0;
    t_en = 4'b0100;
    step();
    chk("os_c1", 32'(ch(2)), 32'd1);
    chk("os_d1", 32'(t_done[2]), 32'h0);
    step();
    chk("os_c0", 32'(ch(2)), 32'd0);
    chk("os_d0", 32'(t_done[2]), 32'h1);
    chk("os_v0", 32'(t_valid[2]), 32'h1);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("os_exp_c", 32'(ch(2)), 32'd0);
      chk("os_exp_v", 32'(t_valid[2]), 32'h0);
      chk("os_exp_d", 32'(t_done[2]), 32'h0);
    end
    cfg(2, 2'b10, 16'd2);
    step();
    cfg_we = 1'b0;
    chk("os_rearm_c", 32'(ch(2)), 32'd2);
    chk("os_rearm_v", 32'(t_valid[2]), 32'h0);
    step();
    chk("os_run_c", 32'(ch(2)), 32'd1);
    chk("os_run_v", 32'(t_valid[2]), 32'h1);
    t_en = 4'b0000;

    // Ch3 UP_CMP load 2, ch0 counting alongside (ch0 currently 1)
    cfg(3, 2'b11, 16'd2);
    step();
    cfg_we = 1'b0;
    chk("cmp_preset", 32'(ch(3)), 32'd0);
    t_en = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("cmp_count", 32'(ch(3)), 32'(exp_cmp[k]));
      chk("cmp_done",  32'(t_done[3]), (k == 2) ? 32'h1 : 32'h0);
      chk("cmp_ch0",   32'(ch(0)), 32'(k + 2));
    end
    cfg(3, 2'b11, 16'd5);
    step();
    cfg_we = 1'b0;
    chk("prio_c3",  32'(ch(3)), 32'd0);
    chk("prio_v3",  32'(t_valid[3]), 32'h0);
    chk("prio_c0",  32'(ch(0)), 32'd6);
    chk("prio_v0",  32'(t_valid[0]), 32'h1);
    step();
    chk("prio_run3", 32'(ch(3)), 32'd1);
    chk("prio_run0", 32'(ch(0)), 32'd7);
    t_en = 4'b0000;

    // Out-of-range channel write is ignored
    cfg(5, 2'b01, 16'h0055);
    step();
    cfg_we = 1'b0;
    chk("oor_c0", 32'(ch(0)), 32'd7);
    chk("oor_c1", 32'(ch(1)), 32'd2);
    chk("oor_c2", 32'(ch(2)), 32'd1);
    chk("oor_c3", 32'(ch(3)), 32'd1);
    chk("oor_v",  32'(t_valid), 32'h0);

    // Reset mid-count, with competing cfg_we and t_en
    t_en = 4'b1111;
    step();
    chk("pre_rst_c0", 32'(ch(0)), 32'd8);
    chk("pre_rst_c1", 32'(ch(1)), 32'd1);
    chk("pre_rst_d2", 32'(t_done[2]), 32'h1);
    rst = 1'b1;
    cfg(1, 2'b01, 16'd9);
    step();
    chk("rst_out_l", t_out[31:0], 32'h0);
    chk("rst_out_h", t_out[63:32], 32'h0);
    chk("rst_valid", 32'(t_valid), 32'h0);
    chk("rst_done",  32'(t_done), 32'h0);
    rst = 1'b0;
    cfg_we = 1'b0;
    t_en = 4'b0101;
    step();
    chk("post_rst_c0", 32'(ch(0)), 32'd1);
    chk("post_rst_c1", 32'(ch(1)), 32'd0);
    chk("post_rst_c2", 32'(ch(2)), 32'd1);
    chk("post_rst_v",  32'(t_valid), 32'h5);
    t_en = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
